// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg: shared constants for the memory-mapped timer.
// Register offsets are word indices taken from address[4:2].
package mmio_timer_pkg;

  // Default window base; the window covers BASE..BASE+0x1F.
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_FF00;

  // Word-index offsets inside the 32-byte window.
  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_COUNT    = 3'd1;
  localparam logic [2:0] OFF_COMPARE  = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  // CTRL register layout.
  localparam int CTRL_W  = 3;
  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;

  // STATUS register layout.
  localparam int STATUS_MATCH = 0;

endpackage

// File: rtl/mmio_timer_tick.sv
// tick_gen: prescaler for the timer. Produces a one-cycle tick every
// (divisor + 1) enabled cycles. A load_clear restarts the division so a
// new divisor always starts from a clean phase.
module tick_gen #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] divisor,
  input  logic                  load_clear,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;

  // The tick is a pure function of the current count and divisor, so the
  // counting logic in the top sees it in the same cycle the wrap happens.
  assign tick = en && (pcnt == divisor);

  // Prescaler counter: holds while disabled, wraps to zero on a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (load_clear) begin
      pcnt <= '0;
    end else if (en) begin
      if (pcnt == divisor) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 32-bit timer living beside Memoria on the CPU
// data port. Decodes a 32-byte window, returns registered read data with
// a matching hit flag one cycle later, and raises a level interrupt when
// the counter matches COMPARE and interrupts are enabled.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  // Decode signals
  logic       in_win;
  logic [2:0] offset;
  logic       wr_en;
  logic       wr_ctrl;
  logic       wr_count;
  logic       wr_compare;
  logic       wr_status;
  logic       wr_prescale;
  logic       unused_addr_lsbs;

  // Architectural state
  logic [CTRL_W-1:0]     ctrl;
  logic [31:0]           count;
  logic [31:0]           compare;
  logic                  match_flag;
  logic [PRESCALE_W-1:0] prescale;

  // Timer datapath
  logic        tick;
  logic        count_eq;
  logic        match_set;
  logic [31:0] count_next_tick;
  logic [31:0] read_mux;

  // Word accesses only; the byte lane bits carry no meaning here.
  assign unused_addr_lsbs = ^address[1:0];

  assign in_win = (address[31:5] == BASE_ADDR[31:5]);
  assign offset = address[4:2];
  assign wr_en  = wr && in_win;

  assign wr_ctrl     = wr_en && (offset == OFF_CTRL);
  assign wr_count    = wr_en && (offset == OFF_COUNT);
  assign wr_compare  = wr_en && (offset == OFF_COMPARE);
  assign wr_status   = wr_en && (offset == OFF_STATUS);
  assign wr_prescale = wr_en && (offset == OFF_PRESCALE);

  // A CPU write to COUNT replaces the old value entirely, so a match
  // against that stale value must not be flagged in the same cycle.
  assign count_eq  = (count == compare);
  assign match_set = tick && !wr_count && count_eq;

  // Value COUNT takes on a tick: reload to zero only on a match with
  // auto_reload set, otherwise a plain increment that wraps naturally.
  assign count_next_tick = (count_eq && ctrl[CTRL_AR]) ? 32'd0 : (count + 32'd1);

  // Interrupt depends on registered state only.
  assign irq = match_flag && ctrl[CTRL_IE];

  tick_gen #(
    .PRESCALE_W(PRESCALE_W)
  ) u_tick_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (ctrl[CTRL_EN]),
    .divisor   (prescale),
    .load_clear(wr_prescale),
    .tick      (tick)
  );

  // CTRL register: only the defined bits are stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl <= wdata[CTRL_W-1:0];
    end
  end

  // COUNT register: CPU write has priority over the tick update.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 32'd0;
    end else if (wr_count) begin
      count <= wdata;
    end else if (tick) begin
      count <= count_next_tick;
    end
  end

  // COMPARE register: resets to all ones so a fresh timer never matches early.
  always_ff @(posedge clk) begin
    if (reset) begin
      compare <= 32'hFFFF_FFFF;
    end else if (wr_compare) begin
      compare <= wdata;
    end
  end

  // Sticky match flag: a new match beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_flag <= 1'b0;
    end else if (match_set) begin
      match_flag <= 1'b1;
    end else if (wr_status && wdata[STATUS_MATCH]) begin
      match_flag <= 1'b0;
    end
  end

  // PRESCALE register; the prescaler phase is cleared by the same write.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
    end else if (wr_prescale) begin
      prescale <= wdata[PRESCALE_W-1:0];
    end
  end

  // Read mux over current state, so a write cycle returns the old value.
  always_comb begin
    read_mux = 32'd0;
    if (in_win) begin
      case (offset)
        OFF_CTRL:     read_mux = 32'(ctrl);
        OFF_COUNT:    read_mux = count;
        OFF_COMPARE:  read_mux = compare;
        OFF_STATUS:   read_mux = 32'(match_flag);
        OFF_PRESCALE: read_mux = 32'(prescale);
        default:      read_mux = 32'd0;
      endcase
    end
  end

  // Registered read port with the same one-cycle latency as Memoria.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= 32'd0;
      hit   <= 1'b0;
    end else begin
      rdata <= read_mux;
      hit   <= in_win;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed scoreboard bench for the memory-mapped timer.
// Each bus access pushes its expected read-back and hit, then the entry
// is popped and compared one cycle later when the registered port updates.
module tb_mmio_timer;

  localparam logic [31:0] BASE       = 32'hFFFF_FF00;
  localparam logic [31:0] A_CTRL     = BASE + 32'h00;
  localparam logic [31:0] A_COUNT    = BASE + 32'h04;
  localparam logic [31:0] A_COMPARE  = BASE + 32'h08;
  localparam logic [31:0] A_STATUS   = BASE + 32'h0C;
  localparam logic [31:0] A_PRESCALE = BASE + 32'h10;
  localparam logic [31:0] A_RSVD14   = BASE + 32'h14;
  localparam logic [31:0] A_RSVD1C   = BASE + 32'h1C;
  localparam logic [31:0] IDLE_ADDR  = 32'h0000_1000;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  int assert_count;
  int fail_count;

  logic [32:0] exp_q[$];
  string       tag_q[$];

  mmio_timer #(
    .BASE_ADDR (BASE),
    .PRESCALE_W(16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .address(address),
    .wr     (wr),
    .wdata  (wdata),
    .rdata  (rdata),
    .hit    (hit),
    .irq    (irq)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one bus cycle on the falling edge, return just after the rising edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic w, input logic [31:0] data);
    @(negedge clk);
    address = addr;
    wr      = w;
    wdata   = data;
    @(posedge clk);
    #1;
    wr      = 1'b0;
    address = IDLE_ADDR;
    wdata   = 32'd0;
  endtask

  // Pop the oldest expectation and compare it with the registered port.
  task automatic checkOutput();
    logic [32:0] exp_entry;
    string       tag;
    assert_count++;
    assert (exp_q.size() != 0) else begin
      fail_count++;
      $error("[TB] FAIL scoreboard_underflow: observed empty expected entry");
    end
    if (exp_q.size() != 0) begin
      exp_entry = exp_q.pop_front();
      tag       = tag_q.pop_front();
      assert_count++;
      assert (rdata === exp_entry[31:0]) else begin
        fail_count++;
        $error("[TB] FAIL %s rdata: observed %h expected %h", tag, rdata, exp_entry[31:0]);
      end
      assert_count++;
      assert (hit === exp_entry[32]) else begin
        fail_count++;
        $error("[TB] FAIL %s hit: observed %b expected %b", tag, hit, exp_entry[32]);
      end
    end
  endtask

  // One access with its expected read-back value and hit.
  task automatic expectAccess(input string tag, input logic [31:0] addr, input logic w,
                              input logic [31:0] data, input logic [31:0] exp_rd,
                              input logic exp_hit);
    exp_q.push_back({exp_hit, exp_rd});
    tag_q.push_back(tag);
    applyStimulus(addr, w, data);
    checkOutput();
  endtask

  task automatic checkIrq(input string tag, input logic exp_irq);
    assert_count++;
    assert (irq === exp_irq) else begin
      fail_count++;
      $error("[TB] FAIL %s irq: observed %b expected %b", tag, irq, exp_irq);
    end
  endtask

  task automatic checkWord(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    reset   = 1'b1;
    address = IDLE_ADDR;
    wr      = 1'b0;
    wdata   = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkWord("reset_rdata", rdata, 32'd0);
    checkWord("reset_hit", {31'd0, hit}, 32'd0);
    checkIrq("reset_irq", 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Basic decode and reset values
    expectAccess("rd_compare_reset", A_COMPARE, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b1);
    expectAccess("rd_outside", 32'h0000_0040, 1'b0, 32'd0, 32'd0, 1'b0);
    expectAccess("rd_ctrl_reset", A_CTRL, 1'b0, 32'd0, 32'd0, 1'b1);
    expectAccess("rd_count_reset", A_COUNT, 1'b0, 32'd0, 32'd0, 1'b1);
    expectAccess("rd_status_reset", A_STATUS, 1'b0, 32'd0, 32'd0, 1'b1);
    expectAccess("rd_prescale_reset", A_PRESCALE, 1'b0, 32'd0, 32'd0, 1'b1);

    // Writes outside the window or to reserved slots change nothing
    expectAccess("wr_outside_low", 32'h0000_0004, 1'b1, 32'd123, 32'd0, 1'b0);
    expectAccess("wr_below_window", 32'hFFFF_FE08, 1'b1, 32'd77, 32'd0, 1'b0);
    expectAccess("wr_reserved", A_RSVD14, 1'b1, 32'h0000_FFFF, 32'd0, 1'b1);
    expectAccess("rd_reserved14", A_RSVD14, 1'b0, 32'd0, 32'd0, 1'b1);
    expectAccess("rd_reserved1c", A_RSVD1C, 1'b0, 32'd0, 32'd0, 1'b1);
    expectAccess("rd_count_untouched", A_COUNT, 1'b0, 32'd0, 32'd0, 1'b1);
    expectAccess("rd_compare_byte_off", BASE + 32'h0B, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b1);

    // Prescaled counting with auto-reload and interrupt
    expectAccess("wr_prescale3", A_PRESCALE, 1'b1, 32'hABCD_0003, 32'd0, 1'b1);
    expectAccess("wr_compare5_old", A_COMPARE, 1'b1, 32'd5, 32'hFFFF_FFFF, 1'b1);
    expectAccess("rd_prescale3", A_PRESCALE, 1'b0, 32'd0, 32'd3, 1'b1);
    expectAccess("wr_ctrl7", A_CTRL, 1'b1, 32'h0000_00FF, 32'd0, 1'b1);
    for (int n = 1; n <= 25; n++) begin
      logic [31:0] exp_cnt;
      exp_cnt = (n - 1 < 24) ? 32'((n - 1) / 4) : 32'd0;
      expectAccess($sformatf("count_run_%0d", n), A_COUNT, 1'b0, 32'd0, exp_cnt, 1'b1);
      checkIrq($sformatf("irq_run_%0d", n), n >= 24);
    end
    expectAccess("rd_status_matched", A_STATUS, 1'b0, 32'd0, 32'd1, 1'b1);
    expectAccess("wr_ctrl_off", A_CTRL, 1'b1, 32'd0, 32'd7, 1'b1);
    expectAccess("wr_status_clear", A_STATUS, 1'b1, 32'd1, 32'd1, 1'b1);
    checkIrq("irq_after_clear", 1'b0);

    // Wrap from all ones without auto-reload gives no match
    applyStimulus(A_PRESCALE, 1'b1, 32'd0);
    applyStimulus(A_COMPARE, 1'b1, 32'd7);
    applyStimulus(A_COUNT, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(A_CTRL, 1'b1, 32'd1);
    expectAccess("wrap_before", A_COUNT, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b1);
    expectAccess("wrap_after", A_COUNT, 1'b0, 32'd0, 32'd0, 1'b1);
    expectAccess("wrap_no_match", A_STATUS, 1'b0, 32'd0, 32'd0, 1'b1);
    expectAccess("wr_ctrl_stop", A_CTRL, 1'b1, 32'd0, 32'd1, 1'b1);
    expectAccess("count_stopped_a", A_COUNT, 1'b0, 32'd0, 32'd3, 1'b1);
    expectAccess("count_stopped_b", A_COUNT, 1'b0, 32'd0, 32'd3, 1'b1);

    // Write-1-to-clear colliding with a match: set wins
    applyStimulus(A_COMPARE, 1'b1, 32'd10);
    applyStimulus(A_COUNT, 1'b1, 32'd8);
    applyStimulus(A_CTRL, 1'b1, 32'd5);
    applyStimulus(IDLE_ADDR, 1'b0, 32'd0);
    applyStimulus(IDLE_ADDR, 1'b0, 32'd0);
    expectAccess("w1c_on_match", A_STATUS, 1'b1, 32'd1, 32'd0, 1'b1);
    checkIrq("irq_set_wins", 1'b1);
    expectAccess("status_set_wins", A_STATUS, 1'b0, 32'd0, 32'd1, 1'b1);
    expectAccess("w1c_idle", A_STATUS, 1'b1, 32'd1, 32'd1, 1'b1);
    checkIrq("irq_cleared", 1'b0);
    expectAccess("status_cleared", A_STATUS, 1'b0, 32'd0, 32'd0, 1'b1);

    // CPU write to COUNT in a tick cycle wins over the increment
    expectAccess("wr_count100", A_COUNT, 1'b1, 32'd100, 32'd14, 1'b1);
    expectAccess("count_write_wins", A_COUNT, 1'b0, 32'd0, 32'd100, 1'b1);
    expectAccess("count_after_write", A_COUNT, 1'b0, 32'd0, 32'd101, 1'b1);

    // Mid-count match, then reset returns everything to reset values
    applyStimulus(A_COMPARE, 1'b1, 32'd51);
    applyStimulus(A_COUNT, 1'b1, 32'd50);
    checkIrq("irq_pre_match", 1'b0);
    applyStimulus(IDLE_ADDR, 1'b0, 32'd0);
    checkIrq("irq_pre_match2", 1'b0);
    applyStimulus(IDLE_ADDR, 1'b0, 32'd0);
    checkIrq("irq_match_mid", 1'b1);
    @(negedge clk);
    reset   = 1'b1;
    address = A_COUNT;
    @(posedge clk);
    #1;
    checkWord("midreset_rdata", rdata, 32'd0);
    checkWord("midreset_hit", {31'd0, hit}, 32'd0);
    checkIrq("midreset_irq", 1'b0);
    @(negedge clk);
    reset   = 1'b0;
    address = IDLE_ADDR;
    expectAccess("post_rst_ctrl", A_CTRL, 1'b0, 32'd0, 32'd0, 1'b1);
    expectAccess("post_rst_count", A_COUNT, 1'b0, 32'd0, 32'd0, 1'b1);
    expectAccess("post_rst_compare", A_COMPARE, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b1);
    expectAccess("post_rst_status", A_STATUS, 1'b0, 32'd0, 32'd0, 1'b1);
    expectAccess("post_rst_prescale", A_PRESCALE, 1'b0, 32'd0, 32'd0, 1'b1);
    repeat (3) applyStimulus(IDLE_ADDR, 1'b0, 32'd0);
    expectAccess("post_rst_count_held", A_COUNT, 1'b0, 32'd0, 32'd0, 1'b1);
    checkIrq("post_rst_irq", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
